combat_resolver: RTL and testbench



---
 rtl/fight_pkg.sv | 55 +++++
 rtl/hit_check.sv | 17 +
 rtl/combat_resolver.sv | 153 +++++++++++++++
 tb/tb_combat_resolver.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared encodings and constants for the combat resolver slice.
// Holds character states, box offsets, damage/stun defaults, winner codes.
package fight_pkg;

    typedef enum logic [3:0] {
        ST_IDLE           = 4'd0,
        ST_WALK_FWD       = 4'd1,
        ST_WALK_BACK      = 4'd2,
        ST_BASIC_STARTUP  = 4'd3,
        ST_BASIC_ACTIVE   = 4'd4,
        ST_BASIC_RECOVERY = 4'd5,
        ST_DIR_STARTUP    = 4'd6,
        ST_DIR_ACTIVE     = 4'd7,
        ST_DIR_RECOVERY   = 4'd8,
        ST_HITSTUN        = 4'd9,
        ST_BLOCKSTUN      = 4'd10
    } char_state_e;

    typedef enum logic [1:0] {
        R_RESET = 2'd0,
        R_FIGHT = 2'd1,
        R_KO    = 2'd2
    } res_state_e;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_P1     = 2'b01,
        WIN_P2     = 2'b10,
        WIN_DOUBLE = 2'b11
    } winner_e;

    // x offsets from sprite left edge
    localparam int HIT_L     = 45;
    localparam int HIT_R     = 58;
    localparam int HIT_M_L   = 6;
    localparam int HIT_M_R   = 19;
    localparam int HURT_L    = 20;
    localparam int HURT_R    = 44;

    localparam int DEF_MAX_HEALTH  = 100;
    localparam int DEF_BASIC_DMG   = 10;
    localparam int DEF_DIR_DMG     = 15;
    localparam int DEF_HITSTUN     = 18;
    localparam int DEF_BLOCKSTUN   = 12;

    function automatic logic is_live(input logic [3:0] st);
        return (st == ST_BASIC_ACTIVE) || (st == ST_DIR_ACTIVE);
    endfunction

    function automatic logic can_block(input logic [3:0] st);
        return (st == ST_IDLE) || (st == ST_WALK_BACK) ||
               (st == ST_BLOCKSTUN);
    endfunction

endpackage

// File: rtl/hit_check.sv
// Combinational attack test: attacker live and hitbox overlaps hurtbox.
// Ports: atk_state, atk_l/atk_r, def_l/def_r in (11-bit x); live_overlap out.
module hit_check
    import fight_pkg::*;
(
    input  logic [3:0]  atk_state,
    input  logic [10:0] atk_l,
    input  logic [10:0] atk_r,
    input  logic [10:0] def_l,
    input  logic [10:0] def_r,
    output logic        live_overlap
);

    assign live_overlap = is_live(atk_state) &&
                          (atk_l < def_r) && (def_l < atk_r);

endmodule

// File: rtl/combat_resolver.sv
// Per-frame hit detection, damage, stun requests and KO tracking.
// Ports: clk, rst, frame_tick, p*_state/pos_x/block in; p*_health, p*_stun_req,
// p*_stun_block, p*_stun_frames, game_over, winner out.
// Option: define COMBAT_CHIP_DAMAGE_EN for chip damage on blocked hits.
module combat_resolver
    import fight_pkg::*;
#(
    parameter int MAX_HEALTH       = DEF_MAX_HEALTH,
    parameter int BASIC_DMG        = DEF_BASIC_DMG,
    parameter int DIR_DMG          = DEF_DIR_DMG,
    parameter int HITSTUN_FRAMES   = DEF_HITSTUN,
    parameter int BLOCKSTUN_FRAMES = DEF_BLOCKSTUN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_pos_x,
    input  logic [9:0] p2_pos_x,
    input  logic       p1_block,
    input  logic       p2_block,
    output logic [6:0] p1_health,
    output logic [6:0] p2_health,
    output logic       p1_stun_req,
    output logic       p2_stun_req,
    output logic       p1_stun_block,
    output logic       p2_stun_block,
    output logic [4:0] p1_stun_frames,
    output logic [4:0] p2_stun_frames,
    output logic       game_over,
    output logic [1:0] winner
);

    res_state_e rstate;
    logic       latch12;
    logic       latch21;
    logic       ov12;
    logic       ov21;

    // 11-bit math keeps boxes near x=1023 from wrapping
    logic [10:0] x1;
    logic [10:0] x2;
    assign x1 = {1'b0, p1_pos_x};
    assign x2 = {1'b0, p2_pos_x};

    hit_check u_p1_to_p2 (
        .atk_state    (p1_state),
        .atk_l        (x1 + 11'(HIT_L)),
        .atk_r        (x1 + 11'(HIT_R)),
        .def_l        (x2 + 11'(HURT_L)),
        .def_r        (x2 + 11'(HURT_R)),
        .live_overlap (ov12)
    );

    hit_check u_p2_to_p1 (
        .atk_state    (p2_state),
        .atk_l        (x2 + 11'(HIT_M_L)),
        .atk_r        (x2 + 11'(HIT_M_R)),
        .def_l        (x1 + 11'(HURT_L)),
        .def_r        (x1 + 11'(HURT_R)),
        .live_overlap (ov21)
    );

    logic hit12;
    logic hit21;
    logic blk1;
    logic blk2;
    assign hit12 = ov12 && !latch12;
    assign hit21 = ov21 && !latch21;
    assign blk1  = p1_block && can_block(p1_state);
    assign blk2  = p2_block && can_block(p2_state);

    function automatic logic [6:0] apply_dmg(
        input logic [6:0] h,
        input logic       hit,
        input logic       blocked,
        input logic       dir
    );
        logic [6:0] dmg;
        logic [6:0] chip;
        dmg  = dir ? 7'(DIR_DMG) : 7'(BASIC_DMG);
        chip = dir ? 7'd2 : 7'd1;
        if (!hit)
            return h;
        if (!blocked)
            return (h > dmg) ? h - dmg : 7'd0;
`ifdef COMBAT_CHIP_DAMAGE_EN
        // chip damage never finishes a player off
        return (h > chip) ? h - chip : ((h == 7'd0) ? 7'd0 : 7'd1);
`else
        return (chip == 7'd0) ? 7'd0 : h;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate         <= R_RESET;
            p1_health      <= 7'(MAX_HEALTH);
            p2_health      <= 7'(MAX_HEALTH);
            p1_stun_req    <= 1'b0;
            p2_stun_req    <= 1'b0;
            p1_stun_block  <= 1'b0;
            p2_stun_block  <= 1'b0;
            p1_stun_frames <= 5'd0;
            p2_stun_frames <= 5'd0;
            game_over      <= 1'b0;
            winner         <= WIN_NONE;
            latch12        <= 1'b0;
            latch21        <= 1'b0;
        end else begin
            p1_stun_req <= 1'b0;
            p2_stun_req <= 1'b0;
            case (rstate)
                R_RESET: rstate <= R_FIGHT;
                R_FIGHT: begin
                    if (p1_health == 7'd0 || p2_health == 7'd0) begin
                        rstate    <= R_KO;
                        game_over <= 1'b1;
                        if (p1_health == 7'd0 && p2_health == 7'd0)
                            winner <= WIN_DOUBLE;
                        else if (p2_health == 7'd0)
                            winner <= WIN_P1;
                        else
                            winner <= WIN_P2;
                    end else if (frame_tick) begin
                        p2_health <= apply_dmg(p2_health, hit12, blk2,
                                               p1_state == ST_DIR_ACTIVE);
                        p1_health <= apply_dmg(p1_health, hit21, blk1,
                                               p2_state == ST_DIR_ACTIVE);
                        // latch spans one active window of the attacker
                        latch12 <= is_live(p1_state) ? (latch12 | ov12) : 1'b0;
                        latch21 <= is_live(p2_state) ? (latch21 | ov21) : 1'b0;
                        if (hit12) begin
                            p2_stun_req    <= 1'b1;
                            p2_stun_block  <= blk2;
                            p2_stun_frames <= blk2 ? 5'(BLOCKSTUN_FRAMES)
                                                   : 5'(HITSTUN_FRAMES);
                        end
                        if (hit21) begin
                            p1_stun_req    <= 1'b1;
                            p1_stun_block  <= blk1;
                            p1_stun_frames <= blk1 ? 5'(BLOCKSTUN_FRAMES)
                                                   : 5'(HITSTUN_FRAMES);
                        end
                    end
                end
                default: rstate <= R_KO;
            endcase
        end
    end

endmodule

// File: tb/tb_combat_resolver.sv
// Scoreboard bench for combat_resolver.
// Expected frames are queued at stimulus time and popped after each edge.
module tb_combat_resolver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] p1_state = 4'd0;
    logic [3:0] p2_state = 4'd0;
    logic [9:0] p1_pos_x = 10'd100;
    logic [9:0] p2_pos_x = 10'd120;
    logic       p1_block = 1'b0;
    logic       p2_block = 1'b0;
    logic [6:0] p1_health;
    logic [6:0] p2_health;
    logic       p1_stun_req;
    logic       p2_stun_req;
    logic       p1_stun_block;
    logic       p2_stun_block;
    logic [4:0] p1_stun_frames;
    logic [4:0] p2_stun_frames;
    logic       game_over;
    logic [1:0] winner;

    always #5 clk = ~clk;

    combat_resolver dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .p1_state       (p1_state),
        .p2_state       (p2_state),
        .p1_pos_x       (p1_pos_x),
        .p2_pos_x       (p2_pos_x),
        .p1_block       (p1_block),
        .p2_block       (p2_block),
        .p1_health      (p1_health),
        .p2_health      (p2_health),
        .p1_stun_req    (p1_stun_req),
        .p2_stun_req    (p2_stun_req),
        .p1_stun_block  (p1_stun_block),
        .p2_stun_block  (p2_stun_block),
        .p1_stun_frames (p1_stun_frames),
        .p2_stun_frames (p2_stun_frames),
        .game_over      (game_over),
        .winner         (winner)
    );

    typedef struct packed {
        logic [6:0] h1;
        logic [6:0] h2;
        logic       r1;
        logic       r2;
        logic       b1;
        logic       b2;
        logic [4:0] f1;
        logic [4:0] f2;
        logic       go;
        logic [1:0] w;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    obs_t got;
    obs_t exp_o;

    function automatic obs_t mk(
        input int h1, input int h2,
        input bit r1, input bit r2, input bit b1, input bit b2,
        input int f1, input int f2, input bit go, input int w
    );
        obs_t o;
        o.h1 = 7'(h1); o.h2 = 7'(h2);
        o.r1 = r1; o.r2 = r2; o.b1 = b1; o.b2 = b2;
        o.f1 = 5'(f1); o.f2 = 5'(f2);
        o.go = go; o.w = 2'(w);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.h1 = p1_health; o.h2 = p2_health;
        o.r1 = p1_stun_req; o.r2 = p2_stun_req;
        o.b1 = p1_stun_block; o.b2 = p2_stun_block;
        o.f1 = p1_stun_frames; o.f2 = p2_stun_frames;
        o.go = game_over; o.w = winner;
        return o;
    endfunction

    task automatic frame(input int s1, input int s2, input int x1,
                         input int x2, input bit bl1, input bit bl2);
        @(negedge clk);
        p1_state = 4'(s1); p2_state = 4'(s2);
        p1_pos_x = 10'(x1); p2_pos_x = 10'(x2);
        p1_block = bl1; p2_block = bl2;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; frame_tick = 1'b0;
        p1_state = 4'd0; p2_state = 4'd0;
        p1_block = 1'b0; p2_block = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(mk(100, 100, 0, 0, 0, 0, 0, 0, 0, 0));
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL reset_values got %h want %h", got, exp_o);
        end
        // tick during RESET state must be ignored
        @(negedge clk);
        rst = 1'b0;
        p1_state = 4'd4; p1_pos_x = 10'd100; p2_pos_x = 10'd120;
        frame_tick = 1'b1;
        sb.push_back(mk(100, 100, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL tick_in_reset got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_clean_hit();
        do_reset();
        sb.push_back(mk(100, 90, 0, 1, 0, 0, 0, 18, 0, 0));
        frame(4, 0, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL clean_hit got %h want %h", got, exp_o);
        end
        sb.push_back(mk(100, 90, 0, 0, 0, 0, 0, 18, 0, 0));
        idle_cycle();
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL pulse_width got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_one_hit_latch();
        do_reset();
        sb.push_back(mk(100, 90, 0, 1, 0, 0, 0, 18, 0, 0));
        sb.push_back(mk(100, 90, 0, 0, 0, 0, 0, 18, 0, 0));
        for (int i = 0; i < 2; i++) begin
            frame(4, 0, 100, 120, 0, 0);
            got = sample(); exp_o = sb.pop_front(); n_cmp++;
            if (got !== exp_o) begin
                n_err++;
                $display("FAIL latch_tick%0d got %h want %h", i, got, exp_o);
            end
        end
        // new active window after leaving state 4 hits again
        sb.push_back(mk(100, 90, 0, 0, 0, 0, 0, 18, 0, 0));
        sb.push_back(mk(100, 80, 0, 1, 0, 0, 0, 18, 0, 0));
        frame(5, 0, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL latch_clear got %h want %h", got, exp_o);
        end
        frame(4, 0, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL latch_rehit got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_miss();
        do_reset();
        sb.push_back(mk(100, 100, 0, 0, 0, 0, 0, 0, 0, 0));
        frame(7, 0, 100, 140, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL miss_edge got %h want %h", got, exp_o);
        end
        // hitbox near right screen edge must not wrap
        sb.push_back(mk(100, 100, 0, 0, 0, 0, 0, 0, 0, 0));
        frame(4, 0, 1000, 10, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL miss_wrap got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_block();
        int hb;
        int hs;
`ifdef COMBAT_CHIP_DAMAGE_EN
        hb = 98;
        hs = 88;
`else
        hb = 100;
        hs = 90;
`endif
        do_reset();
        sb.push_back(mk(100, hb, 0, 1, 0, 1, 0, 12, 0, 0));
        frame(7, 0, 100, 120, 0, 1);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL block_hit got %h want %h", got, exp_o);
        end
        // block held while in hitstun does not protect
        sb.push_back(mk(100, hb, 0, 0, 0, 1, 0, 12, 0, 0));
        sb.push_back(mk(100, hs, 0, 1, 0, 0, 0, 18, 0, 0));
        frame(0, 0, 100, 120, 0, 1);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL block_idle got %h want %h", got, exp_o);
        end
        frame(4, 9, 100, 120, 0, 1);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL block_hitstun got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_trade();
        do_reset();
        sb.push_back(mk(90, 90, 1, 1, 0, 0, 18, 18, 0, 0));
        frame(4, 4, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL trade got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_ko();
        int h2;
        int ok;
        do_reset();
        h2 = 100;
        ok = 1;
        for (int i = 0; i < 7; i++) begin
            h2 = h2 - ((i < 5) ? 15 : 10);
            sb.push_back(mk(100, h2, 0, 1, 0, 0, 0, 18, 0, 0));
            frame((i < 5) ? 7 : 4, 0, 100, 120, 0, 0);
            got = sample(); exp_o = sb.pop_front();
            if (got !== exp_o) ok = 0;
            sb.push_back(mk(100, h2, 0, 0, 0, 0, 0, 18, 0, 0));
            frame(0, 0, 100, 120, 0, 0);
            got = sample(); exp_o = sb.pop_front();
            if (got !== exp_o) ok = 0;
        end
        n_cmp++;
        if (ok == 0 || p2_health !== 7'd5) begin
            n_err++;
            $display("FAIL ko_rampdown got %0d want 5", p2_health);
        end
        sb.push_back(mk(100, 0, 0, 1, 0, 0, 0, 18, 0, 0));
        frame(7, 0, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL ko_saturate got %h want %h", got, exp_o);
        end
        sb.push_back(mk(100, 0, 0, 0, 0, 0, 0, 18, 1, 1));
        idle_cycle();
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL ko_game_over got %h want %h", got, exp_o);
        end
        sb.push_back(mk(100, 0, 0, 0, 0, 0, 0, 18, 1, 1));
        sb.push_back(mk(100, 0, 0, 0, 0, 0, 0, 18, 1, 1));
        frame(0, 0, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL ko_idle got %h want %h", got, exp_o);
        end
        frame(7, 4, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL ko_frozen got %h want %h", got, exp_o);
        end
        sb.push_back(mk(100, 100, 0, 0, 0, 0, 0, 0, 0, 0));
        do_reset();
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL ko_reset got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        sb.push_back(mk(90, 90, 1, 1, 0, 0, 18, 18, 0, 0));
        frame(4, 4, 100, 120, 0, 0);
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL mid_setup got %h want %h", got, exp_o);
        end
        @(negedge clk);
        rst = 1'b1;
        p1_state = 4'd7; p2_state = 4'd7;
        frame_tick = 1'b1;
        sb.push_back(mk(100, 100, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        got = sample(); exp_o = sb.pop_front(); n_cmp++;
        if (got !== exp_o) begin
            n_err++;
            $display("FAIL mid_reset got %h want %h", got, exp_o);
        end
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_hit();
        test_one_hit_latch();
        test_miss();
        test_block();
        test_trade();
        test_ko();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
